// File: rtl/intr_ctrl.sv
// intr_ctrl: three-source prioritized interrupt controller with nesting.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   irq_in[2:0]     raw asynchronous request levels, bit 2 highest priority
//   ie              global interrupt enable
//   mask[2:0]       per-source request mask (pending still latches)
//   take            CPU has jumped to int_vec
//   eret            CPU returns from the innermost interrupt
//   int_req         request to the CPU
//   int_id          requested source, 2'd3 when idle
//   int_vec         vector address of int_id, VEC_BASE when idle
//   pending         latched, not-yet-taken requests
//   in_service      nested sources currently being serviced
module intr_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0200,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic        ie,
    input  logic [2:0]  mask,
    input  logic        take,
    input  logic        eret,
    output logic        int_req,
    output logic [1:0]  int_id,
    output logic [31:0] int_vec,
    output logic [2:0]  pending,
    output logic [2:0]  in_service
);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state;
    logic [2:0] s1, s2, s3, rise, elig, avail, top, req_bit, clr;
    logic [1:0] cand;
    logic       cand_ok;
    always_comb begin
        rise    = s2 & ~s3;
        // only sources strictly above the innermost in-service level may preempt
        elig    = in_service[2] ? 3'b000 : in_service[1] ? 3'b100 : in_service[0] ? 3'b110 : 3'b111;
        avail   = pending & ~mask & elig;
        cand_ok = |avail;
        cand    = avail[2] ? 2'd2 : avail[1] ? 2'd1 : 2'd0;
        top     = in_service[2] ? 3'b100 : in_service[1] ? 3'b010 : in_service[0] ? 3'b001 : 3'b000;
        req_bit = 3'b001 << int_id;
        clr     = (state == REQ && take) ? req_bit : 3'b000;
    end
    assign int_req = (state == REQ);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            s1         <= '0;
            s2         <= '0;
            s3         <= '0;
            pending    <= '0;
            in_service <= '0;
            int_id     <= 2'd3;
            int_vec    <= VEC_BASE;
        end else begin
            s1 <= irq_in;
            s2 <= s1;
            s3 <= s2;
            // a same-cycle rise re-sets the bit being taken
            pending    <= (pending & ~clr) | rise;
            // eret pops the innermost level before take pushes the new one
            in_service <= (in_service & ~(eret ? top : 3'b000)) | clr;
            if (state == IDLE) begin
                if (ie && cand_ok) begin
                    state   <= REQ;
                    int_id  <= cand;
                    int_vec <= VEC_BASE + 32'(cand) * VEC_STRIDE;
                end
            end else if (take || !ie || |(mask & req_bit)) begin
                state   <= IDLE;
                int_id  <= 2'd3;
                int_vec <= VEC_BASE;
            end else if (cand_ok && cand > int_id) begin
                int_id  <= cand;
                int_vec <= VEC_BASE + 32'(cand) * VEC_STRIDE;
            end
        end
    end
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed bench for intr_ctrl with a stack-based reference model.
module tb_intr_ctrl;
    logic        clk = 0, rst = 1, ie = 1, take = 0, eret = 0;
    logic [2:0]  irq_in = 0, mask = 0;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [2:0]  pending, in_service;
    int checks = 0, errors = 0;

    intr_ctrl dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .ie(ie), .mask(mask),
        .take(take), .eret(eret), .int_req(int_req), .int_id(int_id),
        .int_vec(int_vec), .pending(pending), .in_service(in_service)
    );

    always #5 clk = ~clk;

    // model: synchronizer history, pending bits, nesting stack of source numbers, requested id
    logic [2:0] h1, h2, h3, m_pend, m_rise, m_isv;
    int stk[$];
    int rid, cur, best;
    bit took;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h1 = 0; h2 = 0; h3 = 0; m_pend = 0; stk.delete(); rid = -1;
        end else begin
            cur = stk.size() > 0 ? stk[$] : -1;
            best = -1;
            for (int i = 0; i < 3; i++)
                if (m_pend[i] && !mask[i] && i > cur) best = i;
            m_rise = h2 & ~h3;
            h3 = h2; h2 = h1; h1 = irq_in;
            took = rid >= 0 && take;
            if (eret && stk.size() > 0) void'(stk.pop_back());
            if (took) begin
                stk.push_back(rid);
                m_pend[rid] = 0;
            end
            m_pend |= m_rise;
            if (rid < 0) begin
                if (ie && best >= 0) rid = best;
            end else if (take || !ie || mask[rid]) rid = -1;
            else if (best > rid) rid = best;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        m_isv = 0;
        foreach (stk[k]) m_isv[stk[k]] = 1'b1;
        chk("m_int_req", 32'(int_req), 32'(rid >= 0));
        chk("m_int_id", 32'(int_id), rid < 0 ? 32'd3 : 32'(rid));
        chk("m_int_vec", int_vec, rid < 0 ? 32'h200 : 32'h200 + 32'(rid) * 32'h10);
        chk("m_pending", 32'(pending), 32'(m_pend));
        chk("m_in_service", 32'(in_service), 32'(m_isv));
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] b);
        irq_in = b;
        step(3);
        irq_in = 0;
    endtask

    task automatic do_take();
        take = 1; step(); take = 0;
    endtask

    task automatic do_eret();
        eret = 1; step(); eret = 0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"}, 32'(int_req), 0);
        chk({tag, "_id"}, 32'(int_id), 3);
        chk({tag, "_vec"}, int_vec, 32'h200);
        chk({tag, "_pend"}, 32'(pending), 0);
        chk({tag, "_isv"}, 32'(in_service), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        step(2);
        chk_reset("rst0");
        rst = 0;
        // single source, basic latency and take
        pulse(3'b001);
        chk("t1_pend_e2", 32'(pending), 32'b001);
        chk("t1_noreq_e2", 32'(int_req), 0);
        step();
        chk("t1_req_e3", 32'(int_req), 1);
        chk("t1_id", 32'(int_id), 0);
        chk("t1_vec", int_vec, 32'h200);
        do_take();
        chk("t1_isv", 32'(in_service), 32'b001);
        chk("t1_pend0", 32'(pending), 0);
        chk("t1_req0", 32'(int_req), 0);
        // nesting and eret
        pulse(3'b100); step();
        chk("t2_id", 32'(int_id), 2);
        chk("t2_vec", int_vec, 32'h220);
        do_take();
        chk("t2_isv101", 32'(in_service), 32'b101);
        eret = 1; step();
        chk("t2_isv001", 32'(in_service), 32'b001);
        step();
        chk("t2_isv000", 32'(in_service), 0);
        step();
        chk("t2_extra_eret", 32'(in_service), 0);
        eret = 0;
        // lower source blocked while higher in service
        pulse(3'b100); step(); do_take();
        pulse(3'b010);
        chk("t3_pend", 32'(pending), 32'b010);
        step();
        chk("t3_noreq", 32'(int_req), 0);
        do_eret();
        chk("t3_isv_clr", 32'(in_service), 0);
        chk("t3_noreq_yet", 32'(int_req), 0);
        step();
        chk("t3_req", 32'(int_req), 1);
        chk("t3_id", 32'(int_id), 1);
        do_take(); do_eret();
        // simultaneous 0 and 2
        pulse(3'b101); step();
        chk("t4_id2", 32'(int_id), 2);
        do_take();
        chk("t4_pend", 32'(pending), 32'b001);
        step(2);
        chk("t4_blocked", 32'(int_req), 0);
        do_eret(); step();
        chk("t4_id0", 32'(int_id), 0);
        chk("t4_req", 32'(int_req), 1);
        do_take(); do_eret();
        // upgrade in REQ, then drop ie
        pulse(3'b010); step();
        chk("t5_id1", 32'(int_id), 1);
        pulse(3'b100);
        chk("t5_pend", 32'(pending), 32'b110);
        step();
        chk("t5_upgrade", 32'(int_id), 2);
        chk("t5_upvec", int_vec, 32'h220);
        ie = 0; step();
        chk("t5_ie_drop", 32'(int_req), 0);
        chk("t5_pend_kept", 32'(pending), 32'b110);
        ie = 1; step();
        chk("t5_rereq", 32'(int_id), 2);
        do_take(); do_eret(); step(); do_take(); do_eret();
        // eret and take in the same cycle
        pulse(3'b001); step(); do_take();
        pulse(3'b100); step();
        chk("t7_id2", 32'(int_id), 2);
        take = 1; eret = 1; step(); take = 0; eret = 0;
        chk("t7_isv", 32'(in_service), 32'b100);
        do_eret();
        // mask behaviour and reset mid-REQ
        mask = 3'b001;
        pulse(3'b001); step(2);
        chk("t6_pend_masked", 32'(pending), 32'b001);
        chk("t6_noreq", 32'(int_req), 0);
        mask = 0; step();
        chk("t6_req_unmask", 32'(int_req), 1);
        mask = 3'b001; step();
        chk("t6_req_masked", 32'(int_req), 0);
        mask = 0; step();
        chk("t6_req_again", 32'(int_req), 1);
        #2 rst = 1;
        #1 chk_reset("t6_async");
        step(); rst = 0;
        step(3);
        chk_reset("t6_after");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
